// File: rtl/noc_port_rr_arbiter4_pkg.sv
// Shared NoC arbitration definitions: port index type, arbiter state
// encoding and the owner-to-select-vector mapping used by both the
// arbiter and the router's 4:1 output select encoder.
package noc_port_rr_arbiter4_pkg;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Encoder select code for an owner. Port 0 is the encoder's default leg,
  // so it maps to all zeros rather than to a one-hot code.
  function automatic logic [3:0] sel_of_owner(input port_idx_t owner);
    logic [3:0] sel;
    case (owner)
      2'd0:    sel = 4'b0000;
      2'd1:    sel = 4'b0010;
      2'd2:    sel = 4'b0100;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // One-hot bit for a port index.
  function automatic logic [3:0] port_onehot(input port_idx_t p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/noc_port_rr_arbiter4_pick4.sv
// noc_rr_pick4: combinational round-robin search over four requests.
// Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit wins.
module noc_rr_pick4
  import noc_port_rr_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  port_idx_t  ptr,
  output logic       found,
  output port_idx_t  winner
);

  // Walk the rotated order from farthest to nearest so the nearest hit wins.
  always_comb begin
    port_idx_t idx;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx    = ptr + port_idx_t'(k);
      found  = found | req[idx];
      winner = req[idx] ? idx : winner;
    end
  end

endmodule

// File: rtl/noc_port_rr_arbiter4.sv
// noc_port_rr_arbiter4: four-input round-robin arbiter for one NoC output
// port. Holds the winning input until its packet ends and re-arbitrates in
// the same cycle as the release, so consecutive packets have no bubble.
// Optional feature macro: NOC_ARB_PKT_LOCK_EN enables packet locking with a
// flit-count limit and sticky pkt_err; without it every transferred flit
// ends the grant (per-flit round robin).
module noc_port_rr_arbiter4
  import noc_port_rr_arbiter4_pkg::*;
#(
  parameter int MAX_PKT_FLITS = 16,
  parameter int CNT_W         = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] tail,
  input  logic       out_ready,
  output logic [3:0] sel_vec,
  output logic       grant_vld,
  output logic [3:0] in_ready,
  output logic       pkt_err
);

  arb_state_e state_r, state_nxt_s;
  port_idx_t  ptr_r, ptr_nxt_s;
  port_idx_t  owner_r, owner_nxt_s;
  logic       grant_vld_r;
  logic [3:0] sel_vec_r;

  logic       fire_s;
  logic       rel_s;
  logic [3:0] pick_req_s;
  port_idx_t  pick_ptr_s;
  logic       found_s;
  port_idx_t  winner_s;

  assign in_ready = (grant_vld_r & out_ready) ? port_onehot(owner_r) : 4'b0000;
  assign fire_s   = req[owner_r] & in_ready[owner_r];

  // While locked, the search is set up for a release this cycle: pointer
  // just past the owner and the owner's own request masked out.
  assign pick_req_s = grant_vld_r ? (req & ~port_onehot(owner_r)) : req;
  assign pick_ptr_s = grant_vld_r ? port_idx_t'(owner_r + 2'd1) : ptr_r;

  noc_rr_pick4 u_pick (
    .req    (pick_req_s),
    .ptr    (pick_ptr_s),
    .found  (found_s),
    .winner (winner_s)
  );

`ifdef NOC_ARB_PKT_LOCK_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_FLITS - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             pkt_err_r;
  logic             force_s;

  assign rel_s   = fire_s & (tail[owner_r] | (cnt_r == CNT_LAST));
  assign force_s = fire_s & ~tail[owner_r] & (cnt_r == CNT_LAST);
  assign pkt_err = pkt_err_r;

  // Flit counter: counts fires of the current packet, cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (rel_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky error flag for packets cut off at the flit limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_err_r <= 1'b0;
    end else begin
      pkt_err_r <= pkt_err_r | force_s;
    end
  end
`else
  logic unused_ok_s;

  assign rel_s       = fire_s;
  assign pkt_err     = 1'b0;
  assign unused_ok_s = ^{tail, 32'(MAX_PKT_FLITS), 32'(CNT_W)};
`endif

  // Next owner/pointer/state: grant from IDLE, or release and re-arbitrate.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    owner_nxt_s = owner_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = LOCK;
          owner_nxt_s = winner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK: begin
        if (rel_s) begin
          ptr_nxt_s = port_idx_t'(owner_r + 2'd1);
          if (found_s) begin
            state_nxt_s = LOCK;
            owner_nxt_s = winner_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered grant outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      owner_r     <= 2'd0;
      grant_vld_r <= 1'b0;
      sel_vec_r   <= 4'b0000;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      owner_r     <= owner_nxt_s;
      grant_vld_r <= (state_nxt_s == LOCK);
      sel_vec_r   <= (state_nxt_s == LOCK) ? sel_of_owner(owner_nxt_s) : 4'b0000;
    end
  end

  assign grant_vld = grant_vld_r;
  assign sel_vec   = sel_vec_r;

endmodule

// File: tb/tb_noc_port_rr_arbiter4.sv
// Directed-vector bench for noc_port_rr_arbiter4 (MAX_PKT_FLITS = 4).
// Each vector drives inputs just after a rising edge and checks outputs at
// the following falling edge. Expected values are hand-computed for the
// build selected by NOC_ARB_PKT_LOCK_EN.
module tb_noc_port_rr_arbiter4;

  localparam int NV = 29;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] tail;
  logic       out_ready;
  logic [3:0] sel_vec;
  logic       grant_vld;
  logic [3:0] in_ready;
  logic       pkt_err;

  int errors = 0;
  int checks = 0;

  // vector: {rst_n, req[4], tail[4], out_ready | exp grant_vld, exp sel_vec[4], exp in_ready[4], exp pkt_err}
  logic [19:0] vec [NV];

  noc_port_rr_arbiter4 #(.MAX_PKT_FLITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .sel_vec   (sel_vec),
    .grant_vld (grant_vld),
    .in_ready  (in_ready),
    .pkt_err   (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [19:0] v;
    rst_n     = 1'b0;
    req       = 4'b0000;
    tail      = 4'b0000;
    out_ready = 1'b1;

    // reset held, then single-flit packet on port 2
    vec[0]  = {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[1]  = {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[2]  = {1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[3]  = {1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0};
    vec[4]  = {1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    // owner 1 three-flit packet with port 3 also requesting
    vec[5]  = {1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[6]  = {1'b1, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0};
    vec[7]  = {1'b1, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0};
    vec[8]  = {1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0};
    // owner 3 non-tail stream with a 5-cycle stall, then forced release
    vec[9]  = {1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0};
    for (int i = 10; i < 15; i++) begin
      vec[i] = {1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0};
    end
    vec[15] = {1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0};
    vec[16] = {1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0};
    vec[17] = {1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0};
    // all ports requesting single-flit packets: rotation 0,1,2,3,0
    vec[18] = {1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1};
    vec[19] = {1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1};
    vec[20] = {1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1};
    vec[21] = {1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1};
    vec[22] = {1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1};
    vec[23] = {1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1};
    // asynchronous reset mid-packet, then arbitration restarts from port 0
    vec[24] = {1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[25] = {1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[26] = {1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0};
    vec[27] = {1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0};
    vec[28] = {1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};

`ifndef NOC_ARB_PKT_LOCK_EN
    // per-flit round robin: every fire hands the port on, no error flag
    vec[7]  = {1'b1, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0};
    vec[10] = {1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[16] = {1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    for (int i = 18; i < 24; i++) begin
      vec[i][0] = 1'b0;
    end
`endif

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      v         = vec[i];
      rst_n     = v[19];
      req       = v[18:15];
      tail      = v[14:11];
      out_ready = v[10];
      @(negedge clk);
      check_eq($sformatf("v%0d grant_vld", i), {7'b0, grant_vld}, {7'b0, v[9]});
      check_eq($sformatf("v%0d sel_vec", i),   {4'b0, sel_vec},   {4'b0, v[8:5]});
      check_eq($sformatf("v%0d in_ready", i),  {4'b0, in_ready},  {4'b0, v[4:1]});
      check_eq($sformatf("v%0d pkt_err", i),   {7'b0, pkt_err},   {7'b0, v[0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
